instr_sequencer: RTL

Program sequencer that feeds the 20-bit instruction input of simple_cpu.
- Holds a small instruction memory that is loaded by the host, plus a program counter.
- Presents each instruction for exactly the number of cycles the CU needs to retire it: std_op takes 3 cycles (DECODE, EXECUTE, WRITE_BACK); loadR and storeR take 4 cycles (adding MEM_ACCESS).
- Sits between the host/testbench and simple_cpu and replaces hand-timed instruction driving.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/prog_rom.sv | 22 ++
 rtl/instr_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu instruction path: class codes, per-class
// retire latencies and the sequencer state encoding.
package cpu_pkg;

  localparam logic [1:0] CLS_HALT  = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int LAT_STD = 3;
  localparam int LAT_MEM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Cycles the CU needs to retire one instruction of the given class.
  function automatic logic [2:0] lat(input logic [1:0] cls);
    return (cls == CLS_STD) ? 3'(LAT_STD) : 3'(LAT_MEM);
  endfunction

endpackage

// File: rtl/prog_rom.sv
// Host-loaded program store: synchronous write port, asynchronous read port.
module prog_rom #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 6
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [PC_BITS-1:0]     waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic [PC_BITS-1:0]     raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Presents each stored instruction to simple_cpu for exactly its retire latency,
// back to back, until a HALT word, the last address, or a stop request.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 6,
  parameter int CNT_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  input  logic                   stop,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam logic [PC_BITS-1:0] PC_LAST = {PC_BITS{1'b1}};

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2:0]             hold_q, hold_d;
  logic                   stop_pend_q, stop_pend_d;

  logic [PC_BITS-1:0]     rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic [1:0]             rd_cls;
  logic                   rom_we;

  // Outside RUN the only word ever needed is mem[0]; in RUN it is the successor.
  assign rd_addr = (state_q == RUN) ? pc_q + 1'b1 : '0;
  assign rd_cls  = rd_data[INSTR_WIDTH-1 -: 2];
  assign rom_we  = prog_we && ((state_q == IDLE) || (state_q == DONE));

  prog_rom #(
    .INSTR_WIDTH(INSTR_WIDTH),
    .PC_BITS    (PC_BITS)
  ) u_prog_rom (
    .clk  (clk),
    .we   (rom_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      pc_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d        = '0;
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          if (rd_cls == CLS_HALT) begin
            state_d = DONE;
            instr_d = '0;
          end else begin
            // One extra cycle on the first word while the CU leaves RESET.
            state_d = RUN;
            instr_d = rd_data;
            hold_d  = lat(rd_cls) + 3'd1;
          end
        end
      end
      RUN: begin
        if (hold_q == 3'd1) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (stop_pend_q || stop || (pc_q == PC_LAST) || (rd_cls == CLS_HALT)) begin
            state_d     = DONE;
            instr_d     = '0;
            hold_d      = '0;
            stop_pend_d = 1'b0;
          end else begin
            pc_d    = pc_q + 1'b1;
            instr_d = rd_data;
            hold_d  = lat(rd_cls);
          end
        end else begin
          hold_d = hold_q - 3'd1;
          if (stop) stop_pend_d = 1'b1;
        end
      end
      DONE: begin
        instr_d = '0;
      end
      default: begin
        state_d     = IDLE;
        instr_d     = '0;
        pc_d        = '0;
        cnt_d       = '0;
        hold_d      = '0;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule
